// File: rtl/synapse_spike_driver.sv
`default_nettype none
// ============================================================================
// synapse_spike_driver : buffers weighted spike events and drives a decaying,
//                        saturating synaptic current with a refractory gap.
// Revision: 1.0
// ============================================================================
module synapse_spike_driver #(
    parameter int W_WIDTH        = 16,
    parameter int I_WIDTH        = 24,
    parameter int DECAY_SHIFT    = 4,
    parameter int REFRACT_CYCLES = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spike_valid,
    input  logic signed [W_WIDTH-1:0] spike_weight,
    output logic                      spike_ready,
    output logic signed [I_WIDTH-1:0] i_out,
    output logic                      i_valid,
    output logic                      busy,
    output logic [7:0]                drop_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

    localparam logic signed [I_WIDTH-1:0] ACC_ONE = I_WIDTH'(1);
    localparam logic signed [I_WIDTH-1:0] ACC_MAX = {1'b0, {(I_WIDTH-1){1'b1}}};
    localparam logic signed [I_WIDTH-1:0] ACC_MIN = {1'b1, {(I_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    state_t                     r_state;
    logic signed [W_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic                       r_ready;
    logic [7:0]                 r_drop;
    logic signed [W_WIDTH-1:0]  r_weight;
    logic signed [I_WIDTH-1:0]  r_acc;
    logic                       r_valid;
    logic [RW-1:0]              r_refract;

    logic                       w_push;
    logic                       w_pop;
    logic [CW-1:0]              w_count_nxt;
    logic signed [I_WIDTH-1:0]  w_shift;
    logic signed [I_WIDTH-1:0]  w_decay;
    logic signed [I_WIDTH:0]    w_sum;
    logic signed [I_WIDTH-1:0]  w_sat;

    assign w_push = spike_valid && r_ready;
    assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Once the shifted term vanishes, step by one toward zero so the tail ends at 0.
    assign w_shift = r_acc >>> DECAY_SHIFT;
    always_comb begin
        w_decay = '0;
        if (w_shift != '0) begin
            w_decay = r_acc - w_shift;
        end else if (r_acc == '0) begin
            w_decay = '0;
        end else if (r_acc[I_WIDTH-1]) begin
            w_decay = r_acc + ACC_ONE;
        end else begin
            w_decay = r_acc - ACC_ONE;
        end
    end

    assign w_sum = {w_decay[I_WIDTH-1], w_decay}
                 + {{(I_WIDTH+1-W_WIDTH){r_weight[W_WIDTH-1]}}, r_weight};

    always_comb begin
        w_sat = w_sum[I_WIDTH-1:0];
        if (w_sum[I_WIDTH] != w_sum[I_WIDTH-1]) begin
            w_sat = w_sum[I_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= spike_weight;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ready   <= 1'b0;
            r_drop    <= '0;
            r_weight  <= '0;
            r_acc     <= '0;
            r_valid   <= 1'b0;
            r_refract <= '0;
        end else begin
            r_count <= w_count_nxt;
            // Readiness looks at next occupancy only, so a full FIFO never passes through.
            r_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + AW'(1);
            end
            if (spike_valid && !r_ready && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_acc <= w_decay;
                    if (w_pop) begin
                        r_weight <= r_mem[r_rd_ptr];
                        r_state  <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_acc     <= w_sat;
                    r_valid   <= 1'b1;
                    r_refract <= RW'(REFRACT_CYCLES - 1);
                    r_state   <= ST_REFRACT;
                end
                ST_REFRACT: begin
                    r_acc <= w_decay;
                    if (r_refract == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_refract <= r_refract - RW'(1);
                    end
                end
                default: begin
                    r_acc   <= w_decay;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spike_ready = r_ready;
    assign i_out       = r_acc;
    assign i_valid     = r_valid;
    assign busy        = (r_state != ST_IDLE) || (r_count != '0);
    assign drop_count  = r_drop;

endmodule
`default_nettype wire
